// File: rtl/key_state_encoder.sv
// Five-button front-panel encoder: sync, debounce, press-edge detect, 3-bit code.
// Optional KEY_STEP_BUTTON_EN adds a debounced btn_next that steps the code 0..4.
module key_state_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  input  logic       btn5,
`ifdef KEY_STEP_BUTTON_EN
  input  logic       btn_next,
`endif
  output logic [2:0] state,
  output logic       valid,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       raw;
  logic [4:0]       sync1_q, sync1_d;
  logic [4:0]       sync2_q, sync2_d;
  logic [4:0]       cand_q, cand_d;
  logic [4:0]       deb_q, deb_d;
  logic [4:0]       deb_p_q, deb_p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             press;
  logic             single;
  logic [2:0]       key_code;

  assign raw = {btn5, btn4, btn3, btn2, btn1};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    deb_p_d = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Only a rise from all-released counts as a press.
  assign press  = (deb_q != 5'b00000) && (deb_p_q == 5'b00000);
  assign single = $onehot(deb_q);

  always_comb begin
    key_code = 3'd0;
    unique case (deb_q)
      5'b00001: key_code = 3'd0;
      5'b00010: key_code = 3'd1;
      5'b00100: key_code = 3'd2;
      5'b01000: key_code = 3'd3;
      5'b10000: key_code = 3'd4;
      default:  key_code = 3'd0;
    endcase
  end

`ifdef KEY_STEP_BUTTON_EN
  logic             nsync1_q, nsync1_d;
  logic             nsync2_q, nsync2_d;
  logic             ncand_q, ncand_d;
  logic             ndeb_q, ndeb_d;
  logic             ndeb_p_q, ndeb_p_d;
  logic [CNT_W-1:0] ncnt_q, ncnt_d;
  logic             step;

  always_comb begin
    nsync1_d = btn_next;
    nsync2_d = nsync1_q;
    ncand_d  = ncand_q;
    ncnt_d   = ncnt_q;
    ndeb_d   = ndeb_q;
    ndeb_p_d = ndeb_q;
    if (nsync2_q != ncand_q) begin
      ncand_d = nsync2_q;
      ncnt_d  = '0;
    end else if (ncnt_q == CNT_MAX) begin
      ndeb_d = ncand_q;
    end else begin
      ncnt_d = ncnt_q + 1'b1;
    end
  end

  assign step = ndeb_q && !ndeb_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nsync1_q <= 1'b0;
      nsync2_q <= 1'b0;
      ncand_q  <= 1'b0;
      ndeb_q   <= 1'b0;
      ndeb_p_q <= 1'b0;
      ncnt_q   <= '0;
    end else begin
      nsync1_q <= nsync1_d;
      nsync2_q <= nsync2_d;
      ncand_q  <= ncand_d;
      ndeb_q   <= ndeb_d;
      ndeb_p_q <= ndeb_p_d;
      ncnt_q   <= ncnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (press) begin
      if (single) begin
        state_d = key_code;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
`ifdef KEY_STEP_BUTTON_EN
    // A direct key in the same cycle wins over the step.
    else if (step) begin
      state_d = (state_q == 3'd4) ? 3'd0 : state_q + 3'd1;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 5'b00000;
      sync2_q <= 5'b00000;
      cand_q  <= 5'b00000;
      deb_q   <= 5'b00000;
      deb_p_q <= 5'b00000;
      cnt_q   <= '0;
      state_q <= 3'b000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      deb_p_q <= deb_p_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_key_state_encoder.sv
// Bench for key_state_encoder: directed plan plus random presses
// against a sample-history reference model.
module tb_key_state_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] raw;
  logic [2:0] state;
  logic       valid;
  logic       err;
`ifdef KEY_STEP_BUTTON_EN
  logic       nxt;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int nv     = 0;
  int ne     = 0;

  logic [4:0] hist[$];
  logic [4:0] m_deb, m_deb_p;
  logic [2:0] m_state;
  logic       m_valid, m_err;
`ifdef KEY_STEP_BUTTON_EN
  logic       nhist[$];
  logic       m_nd, m_nd_p;
`endif

  always #5 clk = ~clk;

  key_state_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn1(raw[0]),
    .btn2(raw[1]),
    .btn3(raw[2]),
    .btn4(raw[3]),
    .btn5(raw[4]),
`ifdef KEY_STEP_BUTTON_EN
    .btn_next(nxt),
`endif
    .state(state),
    .valid(valid),
    .err(err)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_deb   = '0;
    m_deb_p = '0;
    m_state = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
`ifdef KEY_STEP_BUTTON_EN
    nhist.delete();
    m_nd   = 1'b0;
    m_nd_p = 1'b0;
`endif
  endtask

  // A vector is accepted once D+1 consecutive samples agree, two
  // edges of synchronizer delay behind the raw sample.
  task automatic model_edge();
    logic       ev;
    logic [4:0] nd;
    bit         ok;
    ev = (m_deb != 0) && (m_deb_p == 0);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (ev) begin
      if ($countones(m_deb) == 1) begin
        for (int i = 0; i < 5; i++)
          if (m_deb[i]) m_state = 3'(i);
        m_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
`ifdef KEY_STEP_BUTTON_EN
    else if (m_nd && !m_nd_p) begin
      m_state = 3'((int'(m_state) + 1) % 5);
      m_valid = 1'b1;
    end
`endif
    hist.push_back(raw);
    if (hist.size() > D + 3) void'(hist.pop_front());
    nd = m_deb;
    if (hist.size() == D + 3) begin
      ok = 1'b1;
      for (int j = 1; j <= D; j++)
        if (hist[j] != hist[0]) ok = 1'b0;
      if (ok) nd = hist[0];
    end
    m_deb_p = m_deb;
    m_deb   = nd;
`ifdef KEY_STEP_BUTTON_EN
    begin
      logic nn;
      nhist.push_back(nxt);
      if (nhist.size() > D + 3) void'(nhist.pop_front());
      nn = m_nd;
      if (nhist.size() == D + 3) begin
        ok = 1'b1;
        for (int j = 1; j <= D; j++)
          if (nhist[j] != nhist[0]) ok = 1'b0;
        if (ok) nn = nhist[0];
      end
      m_nd_p = m_nd;
      m_nd   = nn;
    end
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("state", 8'(state), 8'(m_state));
      chk("valid", 8'(valid), 8'(m_valid));
      chk("err", 8'(err), 8'(m_err));
      chk("excl", 8'(valid & err), 8'd0);
      if (valid) nv++;
      if (err) ne++;
    end
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_valid"}, 8'(valid), 8'd0);
    chk({tag, "_err"}, 8'(err), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] rv;
    int         sel;
    int         hold;
    raw = 5'b00100;
`ifdef KEY_STEP_BUTTON_EN
    nxt = 1'b0;
`endif
    reset_now("rst");

    nv = 0;
    cyc(7);
    chk("rst_btn3_early", 8'(valid), 8'd0);
    cyc(1);
    chk("rst_btn3_valid", 8'(valid), 8'd1);
    chk("rst_btn3_state", 8'(state), 8'd2);
    cyc(10);
    raw = 5'b00000;
    cyc(12);

    raw = 5'b01000;
    nv = 0;
    cyc(7);
    chk("b4_early", 8'(valid), 8'd0);
    cyc(1);
    chk("b4_valid", 8'(valid), 8'd1);
    chk("b4_state", 8'(state), 8'd3);
    cyc(12);
    chk("b4_pulses", 8'(nv), 8'd1);
    raw = 5'b00000;
    nv = 0;
    ne = 0;
    cyc(12);
    chk("b4_rel_state", 8'(state), 8'd3);
    chk("b4_rel_pulses", 8'(nv + ne), 8'd0);

    raw = 5'b00010;
    cyc(3);
    raw = 5'b00000;
    cyc(12);
    chk("glitch_state", 8'(state), 8'd3);
    chk("glitch_pulses", 8'(nv), 8'd0);
    raw = 5'b00010;
    cyc(6);
    raw = 5'b00000;
    cyc(12);
    chk("b2_6cyc_state", 8'(state), 8'd1);
    chk("b2_6cyc_pulses", 8'(nv), 8'd1);

    nv = 0;
    ne = 0;
    raw = 5'b10001;
    cyc(12);
    chk("multi_err", 8'(ne), 8'd1);
    chk("multi_valid", 8'(nv), 8'd0);
    chk("multi_state", 8'(state), 8'd1);
    ne = 0;
    raw = 5'b10101;
    cyc(12);
    chk("multi_add", 8'(nv + ne), 8'd0);
    raw = 5'b00000;
    cyc(12);

    raw = 5'b10000;
    cyc(12);
    chk("b5_state", 8'(state), 8'd4);
    nv = 0;
    raw = 5'b00010;
    cyc(12);
    chk("swap_state", 8'(state), 8'd4);
    chk("swap_pulses", 8'(nv), 8'd0);
    raw = 5'b00000;
    cyc(12);
    raw = 5'b00010;
    cyc(12);
    chk("repress_state", 8'(state), 8'd1);
    chk("repress_pulses", 8'(nv), 8'd1);
    raw = 5'b00000;
    cyc(12);

`ifdef KEY_STEP_BUTTON_EN
    raw = 5'b01000;
    cyc(12);
    raw = 5'b00000;
    cyc(12);
    chk("step_start", 8'(state), 8'd3);
    nv = 0;
    nxt = 1'b1;
    cyc(12);
    nxt = 1'b0;
    cyc(12);
    chk("step_1", 8'(state), 8'd4);
    nxt = 1'b1;
    cyc(12);
    nxt = 1'b0;
    cyc(12);
    chk("step_2", 8'(state), 8'd0);
    chk("step_pulses", 8'(nv), 8'd2);
    nv = 0;
    raw = 5'b00001;
    nxt = 1'b1;
    cyc(12);
    chk("step_prio_state", 8'(state), 8'd0);
    chk("step_prio_pulses", 8'(nv), 8'd1);
    raw = 5'b00000;
    nxt = 1'b0;
    cyc(12);
`endif

    for (int b = 0; b < 60; b++) begin
      sel = $urandom_range(0, 3);
      rv = 5'($urandom());
      case (sel)
        0:       raw = 5'b00000;
        1:       raw = 5'b00001 << $urandom_range(0, 4);
        2:       raw = rv;
        default: raw = (b % 2 == 0) ? 5'b00000 : 5'b00100;
      endcase
`ifdef KEY_STEP_BUTTON_EN
      nxt = ($urandom_range(0, 3) == 0);
`endif
      if (b == 30) begin
        #2;
        reset_now("midrst");
      end
      hold = $urandom_range(1, 12);
      cyc(hold);
    end
    raw = 5'b00000;
    cyc(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_state_encoder.md
Name: key_state_encoder

Overview:
- Converts five front-panel push buttons into the 3-bit LED/state code consumed by the LED decoder: button N selects state N-1.
- Synchronizes, debounces and edge-detects the buttons, then registers the selected code.
- Sits between the board pushbuttons and the state input of the one-hot LED driver; the output `state` connects directly to it.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable clock cycles required before a button vector is accepted; legal range 2..2^CNT_W.
- CNT_W, 5, width of the debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn1..btn5  input  1 each  raw button levels, active-high, asynchronous to clk.
- state  output  3  selected state code: 3'b000..3'b100; other codes are never driven.
- valid  output  1  one-cycle pulse when `state` has just been loaded by a legal press.
- err  output  1  one-cycle pulse when a press with more than one button was rejected.

Behaviour:
- Reset, while rst_n=0, independent of clk:
  - sync1, sync2, cand and deb are all 5'b00000.
  - cnt is 0.
  - state is 3'b000, valid is 0, err is 0.
- Vector order is {btn5,btn4,btn3,btn2,btn1}; bit i maps to code i.
- Synchronizer: two flops, sync1 <= raw, sync2 <= sync1. No logic between them.
- Debounce:
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= cand, and cnt holds (saturates).
  - Else cnt <= cnt+1.
  - A change shorter than DEBOUNCE_CYCLES+1 cycles never reaches deb.
- Press event: deb goes from 5'b00000 to non-zero between two consecutive cycles.
  - Changes between two non-zero values (adding or swapping keys without a full release) create no event.
  - Holding a key creates no further events.
- On a press event with exactly one bit i set: state <= i, valid <= 1 for one cycle, err stays 0.
- On a press event with two or more bits set: state holds, err <= 1 for one cycle, valid stays 0.
- Releasing all keys (deb returns to 0) leaves state unchanged; valid and err stay 0.
- valid and err are never 1 in the same cycle; both are 0 in every cycle without an event.
- Latency: raw vector sampled into sync1 at edge k and held stable gives:
  - deb updated at edge k+DEBOUNCE_CYCLES+2;
  - state, valid and err updated at edge k+DEBOUNCE_CYCLES+3.
- Reset mid-operation:
  - All registers return to reset values immediately.
  - A key still held when rst_n rises is debounced afresh and produces a normal press event.

Optional Feature:
- Macro: KEY_STEP_BUTTON_EN.
- With the macro defined:
  - Adds input btn_next (1 bit, active-high), synchronized and debounced by its own identical sync/cand/cnt/deb path.
  - A debounced 0->1 edge of btn_next with no direct-key event in the same cycle advances state: 0->1->2->3->4->0 (4 wraps to 0), with a valid pulse.
  - If a direct-key event (valid or err) occurs in the same cycle, the direct key takes priority and the step is dropped.
- Without the macro: port btn_next does not exist and no step logic is present.

Test Plan:
Each scenario uses DEBOUNCE_CYCLES=4.
- Reset: hold rst_n=0 with btn3=1 -> state=3'b000, valid=0, err=0. Release reset with btn3 still held -> state=3'b010 with valid pulse 7 edges after the first sampling edge.
- Single press: btn4 high for 20 cycles at edge k -> state=3'b011 and valid=1 for exactly one cycle at edge k+7. Release -> state stays 3'b011, no pulses.
- Glitch rejection: btn2 high for 3 cycles then low -> state unchanged, valid=0 throughout. btn2 high for 6 cycles -> state=3'b001.
- Multi-key: btn1 and btn5 rise at the same edge -> err pulse once, state keeps previous value. Then add btn3 without release -> no pulse.
- No re-trigger: press btn5 (state=3'b100), switch to btn2 without passing through all-released -> no event, state=3'b100. Release all, press btn2 -> state=3'b001 and valid.
- KEY_STEP_BUTTON_EN defined: from state=3'b011, press btn_next twice -> state 3'b100 then 3'b000, one valid pulse each. btn_next and btn1 debounced in the same cycle -> state=3'b000 from btn1; the step is dropped.
